// File: rtl/kbd_pkg.sv
// kbd_pkg: shared port addresses, status bit layout and command codes for the keyboard port.
package kbd_pkg;
    localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
    localparam logic [15:0] KBD_STAT_PORT = 16'h0064;
    localparam int          OBF_BIT       = 0;
    localparam int          OVF_BIT       = 4;
    localparam logic [7:0]  FLUSH_CMD     = 8'hFF;

    function automatic logic [7:0] status_byte(input logic ovf, input logic obf);
        logic [7:0] s;
        s          = 8'h00;
        s[OVF_BIT] = ovf;
        s[OBF_BIT] = obf;
        return s;
    endfunction
endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous FIFO with wrap-bit pointers; flush overrides push and pop.
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock50,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             empty_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en, rd_en;

    always_comb begin
        empty = wr_ptr_q == rd_ptr_q;
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en = pop && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        wr_en = push && (!full || rd_en) && !flush;
        head  = mem_q[rd_ptr_q[AW-1:0]];
        mem_d = mem_q;
        if (wr_en) mem_d[wr_ptr_q[AW-1:0]] = din;
        wr_ptr_d  = flush ? '0 : wr_ptr_q + (AW+1)'(wr_en);
        rd_ptr_d  = flush ? '0 : rd_ptr_q + (AW+1)'(rd_en);
        empty_nxt = wr_ptr_d == rd_ptr_d;
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock50) mem_q <= mem_d;
endmodule

// File: rtl/kbd_port_fifo.sv
// kbd_port_fifo: buffered PS/2 keyboard data/status ports; define KBD_IRQ_EN for a registered irq level.
module kbd_port_fifo
    import kbd_pkg::*;
#(
    parameter int          DEPTH     = 8,
    parameter logic [15:0] DATA_PORT = KBD_DATA_PORT,
    parameter logic [15:0] STAT_PORT = KBD_STAT_PORT
) (
    input  logic        clock50,
    input  logic        reset,
    input  logic [15:0] port_addr,
    output logic [15:0] port_in,
    input  logic [15:0] port_out,
    input  logic        port_bit,
    input  logic        port_clk,
    input  logic        port_read,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_clk,
    output logic        irq
);
    logic       rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
    logic       ovf_q, ovf_d;
    logic [7:0] last_byte_q, last_byte_d;
    logic       at_data, at_stat, rd_fall, wr_rise, pop, flush, overflow;
    logic [7:0] head;
    logic       empty, full, empty_nxt;
    logic       unused;

    assign unused = ^{port_bit, port_out[15:8], empty_nxt};

    kbd_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clock50  (clock50),
        .reset    (reset),
        .push     (ps2_data_clk),
        .pop      (pop),
        .flush    (flush),
        .din      (ps2_data),
        .head     (head),
        .empty    (empty),
        .full     (full),
        .empty_nxt(empty_nxt)
    );

    always_comb begin
        at_data   = port_addr == DATA_PORT;
        at_stat   = port_addr == STAT_PORT;
        rd_fall   = rd_prev_q && !port_read;
        wr_rise   = port_clk && !wr_prev_q;
        pop       = rd_fall && at_data && !empty;
        flush     = wr_rise && at_stat && port_out[7:0] == FLUSH_CMD;
        overflow  = ps2_data_clk && full && !pop && !flush;
        rd_prev_d = port_read;
        wr_prev_d = port_clk;
        // Flush beats everything; a fresh overflow beats a status-read clear.
        ovf_d       = flush ? 1'b0 : overflow ? 1'b1 : (rd_fall && at_stat) ? 1'b0 : ovf_q;
        last_byte_d = pop ? head : last_byte_q;
        port_in     = at_data ? {8'h00, empty ? last_byte_q : head} :
                      at_stat ? {8'h00, status_byte(ovf_q, !empty)} : 16'h0000;
    end

    always_ff @(posedge clock50) begin
        if (reset) begin
            rd_prev_q   <= 1'b0;
            wr_prev_q   <= 1'b0;
            ovf_q       <= 1'b0;
            last_byte_q <= 8'h00;
        end else begin
            rd_prev_q   <= rd_prev_d;
            wr_prev_q   <= wr_prev_d;
            ovf_q       <= ovf_d;
            last_byte_q <= last_byte_d;
        end
    end

`ifdef KBD_IRQ_EN
    logic irq_q, irq_d;

    // Registered from next-state emptiness so irq tracks obf cycle for cycle.
    always_comb irq_d = !empty_nxt;

    always_ff @(posedge clock50) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule
